// File: rtl/ddr3_pkg.sv
// ddr3_pkg: shared definitions for the DDR3 command FSM.
//   - DDR3 command encodings {ras_n,cas_n,we_n}
//   - FSM state enumeration
//   - address-map constants (bank field width, auto-precharge bit)
package ddr3_pkg;

  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_NOP = 3'b111;

  // Bank field sits directly above the column field in the request address.
  localparam int BANK_BITS = 3;
  // Column-phase address bit that requests auto-precharge.
  localparam int A10_BIT   = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG       = 3'd1,
    ST_REFRESH   = 3'd2,
    ST_ACT       = 3'd3,
    ST_WRITE     = 3'd4,
    ST_READ      = 3'd5,
    ST_OPEN      = 3'd6,
    ST_PRECHARGE = 3'd7
  } state_e;

endpackage

// File: rtl/ddr3_fsm_amap.sv
// ddr3_fsm_amap: splits a request address (32-bit DFI-word units) into
// DDR3 column, bank and row fields. Purely combinational.
//   adr_i  : request address
//   col_o  : column address, {adr[CSB-1:0],1'b0} (two DFI words per column pair)
//   bank_o : bank, adr[CSB+2:CSB]
//   row_o  : row, adr[ASB:CSB+3]
module ddr3_fsm_amap
  import ddr3_pkg::*;
#(
  parameter int DDR_ROW_BITS = 13,
  parameter int DDR_COL_BITS = 10,
  parameter int ADDRS        = DDR_COL_BITS + DDR_ROW_BITS + 2
) (
  input  logic [ADDRS-1:0]        adr_i,
  output logic [DDR_COL_BITS-1:0] col_o,
  output logic [BANK_BITS-1:0]    bank_o,
  output logic [DDR_ROW_BITS-1:0] row_o
);

  localparam int CSB = DDR_COL_BITS - 1;
  localparam int ASB = ADDRS - 1;

  assign col_o  = {adr_i[CSB-1:0], 1'b0};
  assign bank_o = adr_i[CSB+2:CSB];
  assign row_o  = adr_i[ASB:CSB+3];

endmodule

// File: rtl/ddr3_fsm.sv
// ddr3_fsm: DDR3 command FSM. Turns bus write/read burst requests into
// ACT / WR / RD / PRE commands, issues REF when due, and passes config
// commands (MRS/ZQ...) through to the ddl timing layer.
//   clock, reset (sync, active-high), arst_n (async, active-low)
//   mem_wr*/mem_rd* : request handshake (req held until ack, 1-cycle ack/err)
//   cfg_*           : config command port, cfg_rdy_o accepts
//   ddl_*           : command valid/ready toward the ddl, ddl_ref_i refresh due
module ddr3_fsm
  import ddr3_pkg::*;
#(
  parameter int DDR_FREQ_MHZ = 100,
  parameter int DDR_ROW_BITS = 13,
  parameter int DDR_COL_BITS = 10,
  parameter int REQID        = 4,
  parameter int ADDRS        = DDR_COL_BITS + DDR_ROW_BITS + 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arst_n,
  input  logic                    mem_wrreq_i,
  input  logic                    mem_wrlst_i,
  output logic                    mem_wrack_o,
  output logic                    mem_wrerr_o,
  input  logic [REQID-1:0]        mem_wrtid_i,
  input  logic [ADDRS-1:0]        mem_wradr_i,
  input  logic                    mem_rdreq_i,
  input  logic                    mem_rdlst_i,
  output logic                    mem_rdack_o,
  output logic                    mem_rderr_o,
  input  logic [REQID-1:0]        mem_rdtid_i,
  input  logic [ADDRS-1:0]        mem_rdadr_i,
  input  logic                    cfg_req_i,
  output logic                    cfg_rdy_o,
  input  logic [2:0]              cfg_cmd_i,
  input  logic [2:0]              cfg_ba_i,
  input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
  output logic                    ddl_req_o,
  input  logic                    ddl_rdy_i,
  input  logic                    ddl_ref_i,
  output logic [2:0]              ddl_cmd_o,
  output logic [2:0]              ddl_ba_o,
  output logic [DDR_ROW_BITS-1:0] ddl_adr_o
);

  state_e                  state_q, state_d;
  logic [BANK_BITS-1:0]    bank_q, bank_d;    // target bank of current request
  logic [BANK_BITS-1:0]    obank_q, obank_d;  // bank to precharge on a row miss
  logic [DDR_ROW_BITS-1:0] row_q, row_d;
  logic [DDR_COL_BITS-1:0] col_q, col_d;
  logic                    lst_q, lst_d;
  logic                    dir_q, dir_d;      // 0 = write, 1 = read
  logic                    err_q, err_d;      // pending error for the next ack
  logic [REQID-1:0]        tid_q, tid_d;      // captured, reserved
  logic                    wrack_q, wrack_d, wrerr_q, wrerr_d;
  logic                    rdack_q, rdack_d, rderr_q, rderr_d;
  logic                    run_q, run_d;      // low only while in reset

  logic [DDR_COL_BITS-1:0] wr_col_s, rd_col_s;
  logic [BANK_BITS-1:0]    wr_bank_s, rd_bank_s;
  logic [DDR_ROW_BITS-1:0] wr_row_s, rd_row_s;
  logic [DDR_ROW_BITS-1:0] col_adr_s;
  logic                    xfer_s;

  ddr3_fsm_amap #(.DDR_ROW_BITS(DDR_ROW_BITS), .DDR_COL_BITS(DDR_COL_BITS), .ADDRS(ADDRS))
    u_wr_amap (.adr_i(mem_wradr_i), .col_o(wr_col_s), .bank_o(wr_bank_s), .row_o(wr_row_s));
  ddr3_fsm_amap #(.DDR_ROW_BITS(DDR_ROW_BITS), .DDR_COL_BITS(DDR_COL_BITS), .ADDRS(ADDRS))
    u_rd_amap (.adr_i(mem_rdadr_i), .col_o(rd_col_s), .bank_o(rd_bank_s), .row_o(rd_row_s));

  assign xfer_s      = ddl_req_o & ddl_rdy_i;
  assign mem_wrack_o = wrack_q;
  assign mem_wrerr_o = wrerr_q;
  assign mem_rdack_o = rdack_q;
  assign mem_rderr_o = rderr_q;

  // Column-phase address: column bits with A10 carrying auto-precharge on the last burst.
  always_comb begin
    col_adr_s                     = '0;
    col_adr_s[DDR_COL_BITS-1:0]   = col_q;
    col_adr_s[A10_BIT]            = lst_q;
  end

  // Command outputs decoded from state; registers hold them stable until transfer.
  always_comb begin
    ddl_req_o = 1'b0;
    ddl_cmd_o = CMD_NOP;
    ddl_ba_o  = 3'b000;
    ddl_adr_o = '0;
    cfg_rdy_o = 1'b0;
    case (state_q)
      ST_IDLE: cfg_rdy_o = run_q;
      ST_CFG: begin
        ddl_req_o = cfg_req_i;
        ddl_cmd_o = cfg_cmd_i;
        ddl_ba_o  = cfg_ba_i;
        ddl_adr_o = cfg_adr_i;
        cfg_rdy_o = ddl_rdy_i;
      end
      ST_REFRESH: begin
        ddl_req_o = 1'b1;
        ddl_cmd_o = CMD_REF;
      end
      ST_ACT: begin
        ddl_req_o = 1'b1;
        ddl_cmd_o = CMD_ACT;
        ddl_ba_o  = bank_q;
        ddl_adr_o = row_q;
      end
      ST_WRITE, ST_READ: begin
        ddl_req_o = 1'b1;
        ddl_cmd_o = (state_q == ST_READ) ? CMD_RD : CMD_WR;
        ddl_ba_o  = bank_q;
        ddl_adr_o = col_adr_s;
      end
      ST_PRECHARGE: begin
        ddl_req_o = 1'b1;
        ddl_cmd_o = CMD_PRE;
        ddl_ba_o  = obank_q;
      end
      default: ddl_req_o = 1'b0;
    endcase
  end

  // Next-state and request capture.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    obank_d = obank_q;
    row_d   = row_q;
    col_d   = col_q;
    lst_d   = lst_q;
    dir_d   = dir_q;
    err_d   = err_q;
    tid_d   = tid_q;
    wrack_d = 1'b0;
    wrerr_d = 1'b0;
    rdack_d = 1'b0;
    rderr_d = 1'b0;
    run_d   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (cfg_req_i) begin
          state_d = ST_CFG;
        end else if (ddl_ref_i) begin
          state_d = ST_REFRESH;
        end else if (mem_wrreq_i && !wrack_q) begin
          {bank_d, row_d, col_d} = {wr_bank_s, wr_row_s, wr_col_s};
          {lst_d, tid_d, dir_d, err_d} = {mem_wrlst_i, mem_wrtid_i, 1'b0, 1'b0};
          state_d = ST_ACT;
        end else if (mem_rdreq_i && !rdack_q) begin
          {bank_d, row_d, col_d} = {rd_bank_s, rd_row_s, rd_col_s};
          {lst_d, tid_d, dir_d, err_d} = {mem_rdlst_i, mem_rdtid_i, 1'b1, 1'b0};
          state_d = ST_ACT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CFG:       state_d = cfg_req_i ? ST_CFG : ST_IDLE;
      ST_REFRESH:   state_d = xfer_s ? ST_IDLE : ST_REFRESH;
      ST_PRECHARGE: state_d = xfer_s ? ST_ACT : ST_PRECHARGE;
      ST_ACT: begin
        if (xfer_s) begin
          state_d = dir_q ? ST_READ : ST_WRITE;
        end else begin
          state_d = ST_ACT;
        end
      end
      ST_WRITE, ST_READ: begin
        if (xfer_s) begin
          wrack_d = ~dir_q;
          wrerr_d = ~dir_q & err_q;
          rdack_d = dir_q;
          rderr_d = dir_q & err_q;
          // Last burst was issued with auto-precharge, so the row is already closed.
          state_d = lst_q ? ST_IDLE : ST_OPEN;
        end else begin
          state_d = state_q;
        end
      end
      ST_OPEN: begin
        // Only the direction that opened the row is served; refresh and the
        // other direction wait until the row closes.
        if (!dir_q && mem_wrreq_i && !wrack_q) begin
          obank_d = bank_q;
          {bank_d, row_d, col_d, lst_d, tid_d} = {wr_bank_s, wr_row_s, wr_col_s, mem_wrlst_i, mem_wrtid_i};
          err_d   = !((wr_bank_s == bank_q) && (wr_row_s == row_q));
          state_d = err_d ? ST_PRECHARGE : ST_WRITE;
        end else if (dir_q && mem_rdreq_i && !rdack_q) begin
          obank_d = bank_q;
          {bank_d, row_d, col_d, lst_d, tid_d} = {rd_bank_s, rd_row_s, rd_col_s, mem_rdlst_i, mem_rdtid_i};
          err_d   = !((rd_bank_s == bank_q) && (rd_row_s == row_q));
          state_d = err_d ? ST_PRECHARGE : ST_READ;
        end else begin
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; both resets abandon any command in flight.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      {bank_q, obank_q, row_q, col_q} <= '0;
      {lst_q, dir_q, err_q, tid_q}    <= '0;
      {wrack_q, wrerr_q, rdack_q, rderr_q, run_q} <= 5'b00000;
    end else if (reset) begin
      state_q <= ST_IDLE;
      {bank_q, obank_q, row_q, col_q} <= '0;
      {lst_q, dir_q, err_q, tid_q}    <= '0;
      {wrack_q, wrerr_q, rdack_q, rderr_q, run_q} <= 5'b00000;
    end else begin
      state_q <= state_d;
      {bank_q, obank_q, row_q, col_q} <= {bank_d, obank_d, row_d, col_d};
      {lst_q, dir_q, err_q, tid_q}    <= {lst_d, dir_d, err_d, tid_d};
      {wrack_q, wrerr_q, rdack_q, rderr_q, run_q} <= {wrack_d, wrerr_d, rdack_d, rderr_d, run_d};
    end
  end

endmodule

// File: tb/tb_ddr3_fsm.sv
module tb_ddr3_fsm;

  localparam logic [2:0] C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] adr;
  } cmd_t;

  logic        clock, reset, arst_n;
  logic        mem_wrreq_i, mem_wrlst_i, mem_wrack_o, mem_wrerr_o;
  logic [3:0]  mem_wrtid_i;
  logic [24:0] mem_wradr_i;
  logic        mem_rdreq_i, mem_rdlst_i, mem_rdack_o, mem_rderr_o;
  logic [3:0]  mem_rdtid_i;
  logic [24:0] mem_rdadr_i;
  logic        cfg_req_i, cfg_rdy_o;
  logic [2:0]  cfg_cmd_i, cfg_ba_i;
  logic [12:0] cfg_adr_i;
  logic        ddl_req_o, ddl_rdy_i, ddl_ref_i;
  logic [2:0]  ddl_cmd_o, ddl_ba_o;
  logic [12:0] ddl_adr_o;

  ddr3_fsm dut (
    .clock(clock), .reset(reset), .arst_n(arst_n),
    .mem_wrreq_i(mem_wrreq_i), .mem_wrlst_i(mem_wrlst_i), .mem_wrack_o(mem_wrack_o),
    .mem_wrerr_o(mem_wrerr_o), .mem_wrtid_i(mem_wrtid_i), .mem_wradr_i(mem_wradr_i),
    .mem_rdreq_i(mem_rdreq_i), .mem_rdlst_i(mem_rdlst_i), .mem_rdack_o(mem_rdack_o),
    .mem_rderr_o(mem_rderr_o), .mem_rdtid_i(mem_rdtid_i), .mem_rdadr_i(mem_rdadr_i),
    .cfg_req_i(cfg_req_i), .cfg_rdy_o(cfg_rdy_o), .cfg_cmd_i(cfg_cmd_i),
    .cfg_ba_i(cfg_ba_i), .cfg_adr_i(cfg_adr_i),
    .ddl_req_o(ddl_req_o), .ddl_rdy_i(ddl_rdy_i), .ddl_ref_i(ddl_ref_i),
    .ddl_cmd_o(ddl_cmd_o), .ddl_ba_o(ddl_ba_o), .ddl_adr_o(ddl_adr_o)
  );

  int   checks = 0, errors = 0;
  int   cyc = 0, last_data_cyc = -10;
  int   wr_ack_cnt = 0, rd_ack_cnt = 0;
  int   rdy_mode = 0;           // 0: always ready, 1: random stalls, 2: held low
  bit   cfg_mode = 0, ref_seen = 0;
  cmd_t exp_q[$];
  bit   exp_err;

  // reference model: which row is open, expressed in address arithmetic
  bit          m_open = 0, m_dir = 0;
  int unsigned m_bank = 0, m_row = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // ready driver and refresh-timer stand-in
  initial forever begin
    @(posedge clock);
    #2;
    if (ref_seen) begin
      ddl_ref_i = 1'b0;
      ref_seen  = 1'b0;
    end
    case (rdy_mode)
      0:       ddl_rdy_i = 1'b1;
      1:       ddl_rdy_i = ($urandom_range(0, 3) != 0);
      default: ddl_rdy_i = 1'b0;
    endcase
  end

  // monitor: scoreboard of transferred commands, handshake stability, ack count
  initial begin : monitor
    bit p_valid;
    cmd_t p, cur, e;
    p_valid = 0;
    forever begin
      @(negedge clock);
      cur = '{cmd: ddl_cmd_o, ba: ddl_ba_o, adr: ddl_adr_o};
      if (mem_wrack_o) wr_ack_cnt++;
      if (mem_rdack_o) rd_ack_cnt++;
      if (!arst_n || reset || cfg_mode) begin
        p_valid = 0;
      end else begin
        if (p_valid) begin
          checks++;
          if (ddl_req_o !== 1'b1 || cur !== p) begin
            errors++;
            $display("FAIL stable: req=%b cmd/ba/adr=%h required req=1 %h", ddl_req_o, cur, p);
          end
        end
        if (ddl_req_o === 1'b1 && ddl_rdy_i === 1'b1) begin
          p_valid = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got cmd=%b ba=%0d adr=%h, none required", cur.cmd, cur.ba, cur.adr);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL cmd_seq: got cmd=%b ba=%0d adr=%h required cmd=%b ba=%0d adr=%h",
                       cur.cmd, cur.ba, cur.adr, e.cmd, e.ba, e.adr);
            end
          end
          if (cur.cmd == C_WR || cur.cmd == C_RD) last_data_cyc = cyc;
          if (cur.cmd == C_REF) ref_seen = 1'b1;
        end else begin
          p_valid = (ddl_req_o === 1'b1);
          p = cur;
        end
      end
    end
  end

  function automatic cmd_t mk(logic [2:0] c, int unsigned ba, int unsigned adr);
    cmd_t r;
    r.cmd = c;
    r.ba  = ba[2:0];
    r.adr = adr[12:0];
    return r;
  endfunction

  // expected command list for one burst request, from the address map rules
  task automatic model_req(bit dir, int unsigned adr, bit lst);
    int unsigned col, bank, row;
    col  = (adr % 512) * 2;
    bank = (adr / 512) % 8;
    row  = adr / 4096;
    if (!m_open) begin
      exp_q.push_back(mk(C_ACT, bank, row));
      exp_err = 0;
    end else if (bank == m_bank && row == m_row) begin
      exp_err = 0;
    end else begin
      exp_q.push_back(mk(C_PRE, m_bank, 0));
      exp_q.push_back(mk(C_ACT, bank, row));
      exp_err = 1;
    end
    exp_q.push_back(mk(dir ? C_RD : C_WR, bank, col + (lst ? 1024 : 0)));
    m_open = !lst;
    m_dir  = dir;
    m_bank = bank;
    m_row  = row;
  endtask

  task automatic req_start(bit dir, int unsigned adr, bit lst, logic [3:0] tid);
    model_req(dir, adr, lst);
    @(posedge clock);
    #1;
    if (dir) begin
      mem_rdreq_i = 1'b1; mem_rdadr_i = adr[24:0]; mem_rdlst_i = lst; mem_rdtid_i = tid;
    end else begin
      mem_wrreq_i = 1'b1; mem_wradr_i = adr[24:0]; mem_wrlst_i = lst; mem_wrtid_i = tid;
    end
  endtask

  task automatic req_finish(bit dir);
    bit got, ack, err;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      ack = dir ? mem_rdack_o : mem_wrack_o;
      if (ack === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: dir=%0d no ack within 300 cycles, required one ack", dir);
    end else begin
      err = dir ? mem_rderr_o : mem_wrerr_o;
      checks++;
      if (err !== exp_err) begin
        errors++;
        $display("FAIL ack_err: dir=%0d err=%b required %b", dir, err, exp_err);
      end
      checks++;
      if (cyc != last_data_cyc + 1) begin
        errors++;
        $display("FAIL ack_latency: ack cycle %0d, data transfer cycle %0d, required +1", cyc, last_data_cyc);
      end
    end
    @(posedge clock);
    #1;
    mem_wrreq_i = 1'b0;
    mem_rdreq_i = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_wrack_o !== 1'b0 || mem_rdack_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse: wrack=%b rdack=%b one cycle after ack, required 0 0", mem_wrack_o, mem_rdack_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL cmd_missing: %0d commands not issued, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_req(bit dir, int unsigned adr, bit lst, logic [3:0] tid);
    req_start(dir, adr, lst, tid);
    req_finish(dir);
  endtask

  task automatic test_reset();
    arst_n = 1'b0; reset = 1'b1;
    mem_wrreq_i = 0; mem_wrlst_i = 0; mem_wrtid_i = '0; mem_wradr_i = '0;
    mem_rdreq_i = 0; mem_rdlst_i = 0; mem_rdtid_i = '0; mem_rdadr_i = '0;
    cfg_req_i = 0; cfg_cmd_i = '0; cfg_ba_i = '0; cfg_adr_i = '0;
    ddl_rdy_i = 1'b1; ddl_ref_i = 1'b0;
    #3 arst_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o} !== {1'b0, C_NOP, 3'd0, 13'd0}) begin
      errors++;
      $display("FAIL reset_ddl: req=%b cmd=%b ba=%0d adr=%h required 0 111 0 000", ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o);
    end
    checks++;
    if ({mem_wrack_o, mem_wrerr_o, mem_rdack_o, mem_rderr_o, cfg_rdy_o} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_acks: wrack/wrerr/rdack/rderr/cfg_rdy=%b required 00000",
               {mem_wrack_o, mem_wrerr_o, mem_rdack_o, mem_rderr_o, cfg_rdy_o});
    end
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (cfg_rdy_o !== 1'b1 || ddl_req_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: cfg_rdy=%b req=%b required 1 0", cfg_rdy_o, ddl_req_o);
    end
  endtask

  task automatic test_store_single();
    do_req(0, 16, 1, 4'd1);
  endtask

  task automatic test_open_row();
    do_req(0, 0, 0, 4'd2);
    checks++;
    if (cfg_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL cfg_rdy_open: cfg_rdy=%b with row open, required 0", cfg_rdy_o);
    end
    do_req(0, 8, 1, 4'd3);
    do_req(0, 0, 0, 4'd4);
    do_req(0, 'h1000, 1, 4'd5);
  endtask

  task automatic test_fetch();
    do_req(1, 0, 1, 4'd5);
  endtask

  task automatic test_refresh();
    rdy_mode = 2;
    exp_q.push_back(mk(C_REF, 0, 0));
    req_start(0, 'h2a05, 1, 4'd6);
    ddl_ref_i = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (ddl_req_o !== 1'b1 || ddl_cmd_o !== C_REF) begin
        errors++;
        $display("FAIL ref_hold: cycle %0d req=%b cmd=%b required 1 001", i, ddl_req_o, ddl_cmd_o);
      end
    end
    rdy_mode = 0;
    req_finish(0);
  endtask

  task automatic test_cfg();
    int wr0, rd0;
    logic [2:0] c, b;
    logic [12:0] a;
    wr0 = wr_ack_cnt; rd0 = rd_ack_cnt;
    cfg_mode = 1; rdy_mode = 2;
    @(posedge clock); #1;
    cfg_req_i = 1'b1; cfg_cmd_i = 3'b000; cfg_ba_i = 3'd2; cfg_adr_i = 13'h0520;
    mem_wrreq_i = 1'b1; mem_wradr_i = 25'd77;   // must not be served during config
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, cfg_rdy_o} !== {1'b1, 3'b000, 3'd2, 13'h0520, 1'b0}) begin
      errors++;
      $display("FAIL cfg_mirror: req=%b cmd=%b ba=%0d adr=%h rdy=%b required 1 000 2 0520 0",
               ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, cfg_rdy_o);
    end
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      c = 3'($urandom); b = 3'($urandom); a = 13'($urandom);
      cfg_cmd_i = c; cfg_ba_i = b; cfg_adr_i = a;
      @(negedge clock);
      checks++;
      if ({ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, cfg_rdy_o} !== {1'b1, c, b, a, 1'b1}) begin
        errors++;
        $display("FAIL cfg_follow: req=%b cmd=%b ba=%0d adr=%h rdy=%b required 1 %b %0d %h 1",
                 ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, cfg_rdy_o, c, b, a);
      end
    end
    @(posedge clock); #1;
    cfg_req_i = 1'b0; mem_wrreq_i = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (ddl_req_o !== 1'b0 || cfg_rdy_o !== 1'b1 || wr_ack_cnt != wr0 || rd_ack_cnt != rd0) begin
      errors++;
      $display("FAIL cfg_exit: req=%b rdy=%b acks=%0d/%0d required 0 1 and acks %0d/%0d",
               ddl_req_o, cfg_rdy_o, wr_ack_cnt, rd_ack_cnt, wr0, rd0);
    end
    cfg_mode = 0;
  endtask

  task automatic test_random();
    bit dir, lst;
    int unsigned adr;
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      dir = m_open ? m_dir : 1'($urandom_range(0, 1));
      adr = $urandom_range(0, 2) * 4096 + $urandom_range(0, 1) * 512 + $urandom_range(0, 511);
      lst = (i == 39) ? 1'b1 : ($urandom_range(0, 2) == 0);
      do_req(dir, adr, lst, 4'($urandom));
    end
    rdy_mode = 0;
  endtask

  task automatic test_async_reset();
    int wr0;
    do_req(0, 'h2005, 0, 4'd7);              // leave row 2 open
    rdy_mode = 2;
    @(posedge clock); #1;
    mem_wrreq_i = 1'b1; mem_wradr_i = 25'h5005; mem_wrlst_i = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (ddl_req_o !== 1'b1 || ddl_cmd_o !== C_PRE) begin
      errors++;
      $display("FAIL pre_pending: req=%b cmd=%b required 1 010", ddl_req_o, ddl_cmd_o);
    end
    wr0 = wr_ack_cnt;
    @(posedge clock); #1;
    arst_n = 1'b0;
    #1;
    checks++;
    if (ddl_req_o !== 1'b0 || ddl_cmd_o !== C_NOP || cfg_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_now: req=%b cmd=%b rdy=%b required 0 111 0", ddl_req_o, ddl_cmd_o, cfg_rdy_o);
    end
    mem_wrreq_i = 1'b0;
    m_open = 0;
    @(posedge clock); #1;
    arst_n = 1'b1;
    rdy_mode = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (wr_ack_cnt != wr0 || ddl_req_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_abandon: acks=%0d req=%b required %0d 0", wr_ack_cnt, ddl_req_o, wr0);
    end
    do_req(0, 'h3001, 1, 4'd8);              // row presumed closed: ACT, no PRE
  endtask

  task automatic test_sync_reset();
    int wr0;
    wr0 = wr_ack_cnt;
    rdy_mode = 2;
    @(posedge clock); #1;
    mem_wrreq_i = 1'b1; mem_wradr_i = 25'h0123; mem_wrlst_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (ddl_req_o !== 1'b1 || ddl_cmd_o !== C_ACT) begin
      errors++;
      $display("FAIL act_pending: req=%b cmd=%b required 1 011", ddl_req_o, ddl_cmd_o);
    end
    @(posedge clock); #1;
    reset = 1'b1; mem_wrreq_i = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (ddl_req_o !== 1'b0 || ddl_cmd_o !== C_NOP) begin
      errors++;
      $display("FAIL sreset: req=%b cmd=%b required 0 111", ddl_req_o, ddl_cmd_o);
    end
    @(posedge clock); #1;
    reset = 1'b0; rdy_mode = 0;
    repeat (4) @(negedge clock);
    checks++;
    if (wr_ack_cnt != wr0 || ddl_req_o !== 1'b0 || cfg_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL sreset_idle: acks=%0d req=%b rdy=%b required %0d 0 1", wr_ack_cnt, ddl_req_o, cfg_rdy_o, wr0);
    end
  endtask

  initial begin
    test_reset();
    test_store_single();
    test_open_row();
    test_fetch();
    test_refresh();
    test_cfg();
    test_random();
    test_async_reset();
    test_sync_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_fsm.md
Name: ddr3_fsm

Overview:
DDR3 memory-controller command FSM. Accepts bus-side write and read burst requests, each carrying an address, a last flag and a transaction ID. Translates them into ACTIVATE, READ/WRITE, PRECHARGE and REFRESH commands toward the DDR3 delay/timing layer (ddl), which inserts NOPs to meet DDR3 timing. Also muxes a configuration command port (MRS/ZQ etc.) onto the same ddl command path.

Parameters:
DDR_FREQ_MHZ, 100, DDR clock frequency; reserved for timing-derived constants.
DDR_ROW_BITS, 13, DDR3 row-address width (RSB = DDR_ROW_BITS-1).
DDR_COL_BITS, 10, DDR3 column-address width (CSB = DDR_COL_BITS-1).
REQID, 4, transaction-ID width.
ADDRS, DDR_COL_BITS+DDR_ROW_BITS+2, request-address width in 32-bit DFI-word units (ASB = ADDRS-1).

Ports:
clock in 1 system clock
reset in 1 synchronous, active-high reset
arst_n in 1 asynchronous active-low reset; forces the same state as reset
mem_wrreq_i in 1 write request; held until mem_wrack_o
mem_wrlst_i in 1 last burst of write sequence
mem_wrack_o out 1 one-cycle write-accept pulse
mem_wrerr_o out 1 write error flag, valid with mem_wrack_o
mem_wrtid_i in REQID write transaction ID
mem_wradr_i in ADDRS write address
mem_rdreq_i/mem_rdlst_i/mem_rdack_o/mem_rderr_o/mem_rdtid_i/mem_rdadr_i same widths and meaning, read side
cfg_req_i in 1 config command request
cfg_rdy_o out 1 config port ready/accept
cfg_cmd_i in 3 config command {ras_n,cas_n,we_n}
cfg_ba_i in 3 config bank
cfg_adr_i in DDR_ROW_BITS config address
ddl_req_o out 1 command valid to ddl
ddl_rdy_i in 1 ddl ready; a transfer occurs when ddl_req_o and ddl_rdy_i are both high at a clock edge
ddl_ref_i in 1 refresh due (level, from refresh timer)
ddl_cmd_o out 3 {ras_n,cas_n,we_n}
ddl_ba_o out 3 bank
ddl_adr_o out DDR_ROW_BITS row/column address (A10 = auto-precharge)

Behaviour:
- Command encoding: MRS=000, REF=001, PRE=010, ACT=011, WR=100, RD=101, NOP=111.
- Address map: col = {adr[CSB-1:0],1'b0}; bank = adr[CSB+2:CSB]; row = adr[ASB:CSB+3].
- Reset values: ddl_req_o=0, ddl_cmd_o=NOP, ddl_ba_o=0, ddl_adr_o=0, acks=0, errs=0, cfg_rdy_o=0; state IDLE with no open row.
- Handshake: once ddl_req_o rises, cmd/ba/adr stay stable until the transfer edge. ddl_req_o drops, or loads the next command, on that edge.
- States: IDLE, CFG, REFRESH, ACT, WRITE, READ, OPEN, PRECHARGE.
- IDLE priority, evaluated only when no row is open:
  - cfg_req_i → CFG.
  - Else ddl_ref_i → REFRESH (issue REF).
  - Else mem_wrreq_i → ACT.
  - Else mem_rdreq_i → ACT.
- cfg_rdy_o=1 only in IDLE/CFG with no row open.
- In CFG: ddl_req_o=cfg_req_i, cmd/ba/adr follow cfg inputs combinationally, cfg_rdy_o=ddl_rdy_i. Return to IDLE when cfg_req_i is low.
- ACT: adr=row, ba=bank. After transfer, go to WRITE or READ.
- WRITE/READ: adr = col, with A10 = lst.
  - On transfer, pulse ack for one cycle (registered, visible the cycle after the transfer edge).
  - If lst=1: row closed by auto-precharge → IDLE.
  - If lst=0: → OPEN, recording bank, row and direction.
- OPEN: wait for the next request of the same direction.
  - Same bank and row → issue WR/RD directly, no ACT.
  - Different bank or row → PRECHARGE (A10=0, open bank), then ACT, then WR/RD, with err=1 on that ack.
  - ddl_ref_i is not serviced while OPEN. The opposite-direction request waits.
- A request is never re-accepted in the cycle its ack is high; requesters drop req on seeing ack.
- TID is captured but not returned; reserved.
- reset or arst_n mid-operation: abandon the command, return to IDLE, no ack. The row is presumed closed by system reinit.

Decomposition:
- Package ddr3_pkg: command encodings (CMD_*), FSM state enum, address-map field offsets.
- Optional sub-module ddr3_fsm_amap (pure combinational address split). Otherwise a single module.

Test Plan:
- Reset release, store adr=16 lst=1 tid=1 → ACT ba0 adr0x000, then WR ba0 adr0x420; one wrack pulse, wrerr=0; state returns IDLE.
- Store adr=0 lst=0, then adr=8 lst=1 → ACT 0x000, WR 0x000 (ack), WR 0x410 (ack); no second ACT.
- Fetch adr=0 lst=1 tid=5 → ACT 0x000, RD 0x400, one rdack.
- Store adr=0 lst=0, then adr=0x1000 lst=1 → PRE ba0 adr0x000, ACT row1 (0x001), WR 0x400; second ack carries wrerr=1.
- ddl_ref_i=1 in IDLE with wrreq also pending → REF issued first, then ACT/WR. Holding ddl_rdy_i=0 for 5 cycles keeps ddl_cmd_o and ddl_req_o stable throughout.
- cfg_req_i=1 cmd=000 ba=2 adr=0x0520 in IDLE → ddl outputs mirror cfg inputs; cfg_rdy_o follows ddl_rdy_i; no mem acks.
